// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory-slave controller: default phase width and FSM states.
package spi_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    ADDR_LATCH,
    READ_LOAD,
    READ_SEND,
    WRITE_RECV,
    WRITE_COMMIT,
    DONE
  } spiState_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Serial bit counter for one address/data phase; saturates at WIDTH instead of wrapping.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic atWidth
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !atWidth) begin
      count <= count + 1'b1;
    end
  end

  assign atWidth = (count == CW'(WIDTH));

endmodule

// File: rtl/spi_mem_fsm.sv
// Sequencer for an SPI memory slave: address phase, then read-send or write-receive, with cs_n abort.
//   state        | meaning
//   IDLE         | waiting for cs_n low
//   GET_ADDR     | counting address bits on sclk rising edges
//   ADDR_LATCH   | one clk: latch address, branch on rw_bit
//   READ_LOAD    | one clk: parallel-load shift register from memory
//   READ_SEND    | driving MISO, counting sclk falling edges
//   WRITE_RECV   | counting data bits on sclk rising edges
//   WRITE_COMMIT | one clk: write shifted data into memory
//   DONE         | transaction finished, waiting for cs_n high
module spi_mem_fsm
  import spi_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_posedge,
  input  logic sclk_negedge,
  input  logic cs_n,
  input  logic rw_bit,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_en,
  output logic busy
);

  spiState_t state, nextState;
  logic cntClear, cntEnable, cntDone;

  spi_bit_counter #(.WIDTH(WIDTH)) bitCounter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cntClear),
    .enable  (cntEnable),
    .atWidth (cntDone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    cntClear  = 1'b0;
    cntEnable = 1'b0;
    case (state)
      IDLE: begin
        cntClear = 1'b1;
        if (!cs_n) nextState = GET_ADDR;
      end
      GET_ADDR: begin
        cntEnable = sclk_posedge;
        if (cntDone) nextState = ADDR_LATCH;
      end
      ADDR_LATCH: begin
        cntClear  = 1'b1;
        nextState = rw_bit ? READ_LOAD : WRITE_RECV;
      end
      READ_LOAD: begin
        cntClear  = 1'b1;
        nextState = READ_SEND;
      end
      READ_SEND: begin
        cntEnable = sclk_negedge;
        if (cntDone) nextState = DONE;
      end
      WRITE_RECV: begin
        cntEnable = sclk_posedge;
        if (cntDone) nextState = WRITE_COMMIT;
      end
      WRITE_COMMIT: nextState = DONE;
      DONE: begin
        if (cs_n) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Deselect wins over everything in flight.
    if (cs_n && state != IDLE) begin
      nextState = IDLE;
      cntClear  = 1'b1;
    end
  end

  assign addr_we = (state == ADDR_LATCH)   & ~cs_n;
  assign sr_we   = (state == READ_LOAD)    & ~cs_n;
  assign dm_we   = (state == WRITE_COMMIT) & ~cs_n;
  assign miso_en = (state == READ_SEND)    & ~cs_n;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_spi_mem_fsm.sv
// Scoreboard bench for spi_mem_fsm: stimulus predicts output events by cycle, a monitor matches them.
module tb_spi_mem_fsm;

  localparam int WIDTH = 8;

  localparam int EV_ADDR     = 1;
  localparam int EV_SR       = 2;
  localparam int EV_DM       = 3;
  localparam int EV_MISO_ON  = 4;
  localparam int EV_MISO_OFF = 5;
  localparam int EV_BUSY_OFF = 6;

  typedef struct {
    int code;
    int cyc;
  } expEv_t;

  logic clk = 1'b0;
  logic reset, sclk_posedge, sclk_negedge, cs_n, rw_bit;
  logic addr_we, sr_we, dm_we, miso_en, busy;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;
  logic prevMiso = 1'b0;
  logic prevBusy = 1'b0;
  logic [7:0] shiftReg = 8'h00;
  expEv_t expQ[$];

  spi_mem_fsm #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .cs_n         (cs_n),
    .rw_bit       (rw_bit),
    .addr_we      (addr_we),
    .sr_we        (sr_we),
    .dm_we        (dm_we),
    .miso_en      (miso_en),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string evName(input int code);
    case (code)
      EV_ADDR:     return "addr_we";
      EV_SR:       return "sr_we";
      EV_DM:       return "dm_we";
      EV_MISO_ON:  return "miso_en_rise";
      EV_MISO_OFF: return "miso_en_fall";
      EV_BUSY_OFF: return "busy_fall";
      default:     return "none";
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int code, input int at);
    expEv_t e;
    e.code = code;
    e.cyc  = at;
    expQ.push_back(e);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int code);
    expEv_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL event: got %s at cycle %0d, expected no event", evName(code), cyc);
    end else begin
      e = expQ.pop_front();
      if (e.code != code || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                 evName(code), cyc, evName(e.code), e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (addr_we === 1'b1) observe(EV_ADDR);
      if (sr_we === 1'b1) observe(EV_SR);
      if (dm_we === 1'b1) observe(EV_DM);
      if (miso_en === 1'b1 && prevMiso !== 1'b1) observe(EV_MISO_ON);
      if (miso_en !== 1'b1 && prevMiso === 1'b1) observe(EV_MISO_OFF);
      if (busy !== 1'b1 && prevBusy === 1'b1) observe(EV_BUSY_OFF);
      prevMiso = miso_en;
      prevBusy = busy;
    end
  end

  // Each bit is a one-clk pulse followed by one quiet clk; lastCyc is the cycle of the final pulse.
  task automatic sendByte(input logic [7:0] d, input bit onNeg, input int nBits,
                          input bit stray, output int lastCyc);
    lastCyc = cyc;
    for (int i = 7; i >= 8 - nBits; i--) begin
      if (onNeg) begin
        sclk_negedge = 1'b1;
      end else begin
        sclk_posedge = 1'b1;
        shiftReg = {shiftReg[6:0], d[i]};
        rw_bit = shiftReg[0];
        if (stray && i == 2) sclk_negedge = 1'b1;
      end
      lastCyc = cyc;
      tick();
      sclk_posedge = 1'b0;
      sclk_negedge = 1'b0;
      if (stray && (i == 7 || i == 6)) sclk_negedge = 1'b1;
      tick();
      sclk_negedge = 1'b0;
    end
  endtask

  task automatic doRead(input logic [7:0] a, input bit stray, input int hold, input int negBits);
    int k, m, c;
    cs_n = 1'b0;
    tick();
    sendByte(a, 1'b0, 8, stray, k);
    push(EV_ADDR, k + 2);
    push(EV_SR, k + 3);
    push(EV_MISO_ON, k + 4);
    tick();
    tick();
    sendByte(8'h00, 1'b1, negBits, 1'b0, m);
    if (negBits < WIDTH) begin
      reset = 1'b1;
      c = cyc;
      push(EV_MISO_OFF, c + 1);
      push(EV_BUSY_OFF, c + 1);
      tick();
      reset = 1'b0;
      check("reset addr_we", addr_we, 1'b0);
      check("reset sr_we", sr_we, 1'b0);
      check("reset dm_we", dm_we, 1'b0);
      check("reset miso_en", miso_en, 1'b0);
      check("reset busy", busy, 1'b0);
      cs_n = 1'b1;
      tick();
    end else begin
      push(EV_MISO_OFF, m + 2);
      for (int i = 0; i < hold; i++) begin
        check("done hold busy", busy, 1'b1);
        tick();
      end
      cs_n = 1'b1;
      push(EV_BUSY_OFF, cyc + 1);
      tick();
      tick();
    end
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] d, input int nBits);
    int k, j;
    cs_n = 1'b0;
    tick();
    sendByte(a, 1'b0, 8, 1'b0, k);
    push(EV_ADDR, k + 2);
    tick();
    sendByte(d, 1'b0, nBits, 1'b0, j);
    if (nBits == WIDTH) begin
      push(EV_DM, j + 2);
      tick();
    end
    cs_n = 1'b1;
    push(EV_BUSY_OFF, cyc + 1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cs_n = 1'b1;
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
    rw_bit = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("post-reset addr_we", addr_we, 1'b0);
    check("post-reset sr_we", sr_we, 1'b0);
    check("post-reset dm_we", dm_we, 1'b0);
    check("post-reset miso_en", miso_en, 1'b0);
    check("post-reset busy", busy, 1'b0);
    armed = 1'b1;
    tick();

    doRead(8'h55, 1'b0, 0, WIDTH);
    doWrite(8'hA4, 8'h3C, WIDTH);
    doWrite(8'hA4, 8'h3C, 5);
    doRead(8'h55, 1'b0, 0, 3);
    doRead(8'h55, 1'b0, 0, WIDTH);
    doRead(8'h55, 1'b1, 0, WIDTH);
    doRead(8'h55, 1'b0, 20, WIDTH);

    repeat (5) tick();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d unseen events (first %s at cycle %0d), expected 0",
               expQ.size(), evName(expQ[0].code), expQ[0].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_mem_fsm.md
SPI_MEM_FSM -- requirements
Module: spi_mem_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bits per address/data phase and the shift-register width.
REQ-002 SHALL have port clk, input, 1, FPGA clock; the only clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset sampled on posedge clk.
REQ-004 SHALL have port sclk_posedge, input, 1, single-clk pulse marking a conditioned serial-clock rising edge.
REQ-005 SHALL have port sclk_negedge, input, 1, single-clk pulse marking a conditioned serial-clock falling edge.
REQ-006 SHALL have port cs_n, input, 1, conditioned chip select, active low.
REQ-007 SHALL have port rw_bit, input, 1, shift-register parallelDataOut[0]; 1 = read, 0 = write.
REQ-008 SHALL have port addr_we, output, 1, address-latch write enable.
REQ-009 SHALL have port sr_we, output, 1, drives the shift-register parallelLoad.
REQ-010 SHALL have port dm_we, output, 1, data-memory write enable.
REQ-011 SHALL have port miso_en, output, 1, MISO tristate-buffer enable.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, GET_ADDR, ADDR_LATCH, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_COMMIT and DONE, all updated on posedge clk.
REQ-014 SHALL transition IDLE->GET_ADDR when cs_n=0, with the bit counter cleared to 0.
REQ-015 SHALL, in GET_ADDR, increment the counter on each sclk_posedge and enter ADDR_LATCH on the clk after the WIDTH-th edge.
REQ-016 SHALL hold ADDR_LATCH exactly one clk, then go to READ_LOAD if rw_bit=1 or WRITE_RECV if rw_bit=0, clearing the counter.
REQ-017 SHALL hold READ_LOAD exactly one clk, then go to READ_SEND with the counter cleared.
REQ-018 SHALL, in READ_SEND, count sclk_negedge and enter DONE after WIDTH edges.
REQ-019 SHALL, in WRITE_RECV, count sclk_posedge and enter WRITE_COMMIT after WIDTH edges.
REQ-020 SHALL hold WRITE_COMMIT exactly one clk, then go to DONE.
REQ-021 SHALL hold DONE until cs_n=1, then go to IDLE.
REQ-022 SHALL decode outputs from the current state (Moore), each ANDed with ~cs_n: addr_we=ADDR_LATCH, sr_we=READ_LOAD, dm_we=WRITE_COMMIT, miso_en=READ_SEND.
REQ-023 SHALL make addr_we, sr_we and dm_we exactly one clk wide per transaction.
REQ-024 SHALL enter IDLE on the next clk whenever cs_n=1 in any non-IDLE state; this abort SHALL override every other transition and suppress all outputs in the same cycle.
REQ-025 SHALL ignore edge pulses in states that do not count them; if both sclk pulses arrive in one clk, only the edge relevant to the current state SHALL count.
REQ-026 SHALL size the counter to $clog2(WIDTH+1) bits and SHALL never wrap within a phase.

Reset
REQ-027 SHALL, on reset=1 at posedge clk, force state IDLE and counter 0, overriding abort and all transitions.
REQ-028 SHALL drive addr_we, sr_we, dm_we, miso_en and busy to 0 in the cycle after reset, including when reset is asserted mid-transaction.

Structure
REQ-029 SHALL take the state enumeration and the default WIDTH constant from shared package spi_pkg.
REQ-030 SHALL instantiate one sub-module, spi_bit_counter, providing clear, enable and a count==WIDTH flag.

Verification
REQ-031 SHALL cover read, WIDTH=8: cs_n low, 8 sclk_posedge shifting 0x55 (rw_bit=1) -> addr_we 1-clk pulse, sr_we 1-clk pulse, miso_en high for exactly 8 negedges, dm_we never asserted.
REQ-032 SHALL cover write: 8 posedges with 0xA4 (rw_bit=0), then 8 posedges of data -> addr_we pulse, one dm_we pulse after the 16th edge, miso_en never asserted.
REQ-033 SHALL cover abort: cs_n rises after the 5th data posedge of a write -> IDLE next clk and dm_we never asserted.
REQ-034 SHALL cover reset: reset in READ_SEND after 3 negedges -> all outputs 0 and busy=0 next clk; a fresh read then completes normally.
REQ-035 SHALL cover ignored edges: 3 stray sclk_negedge pulses in GET_ADDR -> the ADDR_LATCH entry cycle is unchanged, still after exactly 8 posedges.
REQ-036 SHALL cover DONE hold: cs_n kept low for 20 clks after a completed read -> stays in DONE, no output pulses, then IDLE one clk after cs_n rises.
